// File: rtl/ball_motion.sv
// ---------------------------------------------------------------------------
// ball_motion
//
// Per-frame sprite position generator. Once per video frame the ball moves
// STEP pixels in the direction picked by the last W/A/S/D keycode (USB HID).
// When the next step would cross a screen limit, the ball bounces back.
//
// The frame strobe (frame_clk, vsync-derived) is asynchronous to Clk. It is
// synchronised with two flops. A third flop holds the previous synchronised
// value, and the rising-edge detector compares against it. The resulting
// tick is high for exactly one Clk cycle per frame, however long frame_clk
// stays high. A position change lands on the 3rd Clk edge after frame_clk
// is first sampled high.
//
// Ports:
//   Clk        in   1   system clock
//   Reset_n    in   1   asynchronous active-low reset (synchronous release
//                       expected from the reset controller)
//   frame_clk  in   1   frame strobe, rising edge = new frame
//   keycode    in   8   current HID keycode, 0x00 = no key
//   BallX      out 10   ball centre column
//   BallY      out 10   ball centre row
//   Ball_size  out 10   constant half-width SIZE
//
// Optional build macro: BALL_PAUSE_KEY_EN
//   When it is defined, a space keycode (0x2C) seen on a tick toggles a
//   paused flag. While the ball is paused, direction keys still steer the
//   FSM, but the ball does not move and does not bounce. The ball also
//   holds still on the tick that toggles the flag, in either direction.
//   When it is not defined, 0x2C is an unrecognised keycode.
// ---------------------------------------------------------------------------
module ball_motion #(
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int STEP     = 1,
  parameter int SIZE     = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size
);

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
`ifdef BALL_PAUSE_KEY_EN
  localparam logic [7:0] KEY_SPACE = 8'h2C;
`endif

  // Limits are 11 bits wide so that the sums cannot wrap around.
  localparam logic [10:0] SIZE_STEP = 11'(SIZE + STEP);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
  localparam logic [10:0] X_LO_LIM  = 11'(X_MIN + SIZE + STEP);
  localparam logic [10:0] Y_LO_LIM  = 11'(Y_MIN + SIZE + STEP);
  localparam logic [9:0]  STEP_W    = 10'(STEP);

  // Frame strobe synchroniser and edge detector
  logic fsync1_q, fsync2_q, fprev_q;
  logic tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync1_q <= 1'b0;
      fsync2_q <= 1'b0;
      fprev_q  <= 1'b0;
    end else begin
      fsync1_q <= frame_clk;
      fsync2_q <= fsync1_q;
      fprev_q  <= fsync2_q;
    end
  end

  assign tick = fsync2_q & ~fprev_q;

  // Direction FSM: state register
  dir_e dir_q, dir_d;
  dir_e key_dir;
  logic hold;
  logic [10:0] x_ext, y_ext;

`ifdef BALL_PAUSE_KEY_EN
  logic paused_q, paused_d;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_q    <= DIR_IDLE;
`ifdef BALL_PAUSE_KEY_EN
      paused_q <= 1'b0;
`endif
    end else begin
      dir_q    <= dir_d;
`ifdef BALL_PAUSE_KEY_EN
      paused_q <= paused_d;
`endif
    end
  end

  assign x_ext = {1'b0, BallX};
  assign y_ext = {1'b0, BallY};

  // Direction FSM: next state. First the key picks a direction. Then, if the
  // ball is free to move, the wall override flips it when the next step
  // would cross a limit.
  always_comb begin
    key_dir = dir_q;
    case (keycode)
      KEY_W:   key_dir = DIR_UP;
      KEY_S:   key_dir = DIR_DOWN;
      KEY_A:   key_dir = DIR_LEFT;
      KEY_D:   key_dir = DIR_RIGHT;
      default: key_dir = dir_q;
    endcase

    hold = 1'b0;
`ifdef BALL_PAUSE_KEY_EN
    paused_d = paused_q;
    if (tick && (keycode == KEY_SPACE)) begin
      paused_d = ~paused_q;
    end
    // Hold while paused and on the tick that toggles the flag.
    hold = paused_q | (keycode == KEY_SPACE);
`endif

    dir_d = dir_q;
    if (tick) begin
      dir_d = key_dir;
      if (!hold) begin
        case (key_dir)
          DIR_RIGHT: if (x_ext + SIZE_STEP > X_MAX_W) dir_d = DIR_LEFT;
          DIR_LEFT:  if (x_ext < X_LO_LIM)            dir_d = DIR_RIGHT;
          DIR_DOWN:  if (y_ext + SIZE_STEP > Y_MAX_W) dir_d = DIR_UP;
          DIR_UP:    if (y_ext < Y_LO_LIM)            dir_d = DIR_DOWN;
          default:   dir_d = key_dir;
        endcase
      end
    end
  end

  // Direction FSM: output. On each tick the ball steps one axis in the
  // final direction.
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;

  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    if (tick && !hold) begin
      case (dir_d)
        DIR_UP:    ball_y_d = ball_y_q - STEP_W;
        DIR_DOWN:  ball_y_d = ball_y_q + STEP_W;
        DIR_LEFT:  ball_x_d = ball_x_q - STEP_W;
        DIR_RIGHT: ball_x_d = ball_x_q + STEP_W;
        default: begin
          ball_x_d = ball_x_q;
          ball_y_d = ball_y_q;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ball_x_q <= 10'(X_CENTER);
      ball_y_q <= 10'(Y_CENTER);
    end else begin
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
    end
  end

  assign BallX     = ball_x_q;
  assign BallY     = ball_y_q;
  assign Ball_size = 10'(SIZE);

endmodule

// File: tb/tb_ball_motion.sv
// Testbench for ball_motion. A behavioural model of position, direction and
// pause flag is stepped once for every frame pulse the bench drives.
module tb_ball_motion;

  localparam int X_CENTER = 320;
  localparam int Y_CENTER = 240;
  localparam int X_MIN = 0;
  localparam int X_MAX = 639;
  localparam int Y_MIN = 0;
  localparam int Y_MAX = 479;
  localparam int STEP = 1;
  localparam int SIZE = 4;

  // model direction codes (bench-local)
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_LEFT = 3, M_RIGHT = 4;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, Ball_size;

  int check_cnt = 0;
  int pass_cnt = 0;

  int m_x, m_y, m_dir;
  bit m_paused;

  ball_motion dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .BallX     (BallX),
    .BallY     (BallY),
    .Ball_size (Ball_size)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic model_reset();
    m_x = X_CENTER;
    m_y = Y_CENTER;
    m_dir = M_IDLE;
    m_paused = 1'b0;
  endtask

  // One frame of the game rules: the key picks a direction, walls reverse it,
  // then the ball steps one axis.
  task automatic model_tick(input logic [7:0] kc);
    bit frozen;
    frozen = 1'b0;
    if (kc == 8'h1A) m_dir = M_UP;
    else if (kc == 8'h16) m_dir = M_DOWN;
    else if (kc == 8'h04) m_dir = M_LEFT;
    else if (kc == 8'h07) m_dir = M_RIGHT;
`ifdef BALL_PAUSE_KEY_EN
    if (kc == 8'h2C) begin
      frozen = 1'b1;
      m_paused = !m_paused;
    end
    if (m_paused) frozen = 1'b1;
`endif
    if (!frozen) begin
      if (m_dir == M_RIGHT && m_x + SIZE + STEP > X_MAX) m_dir = M_LEFT;
      else if (m_dir == M_LEFT && m_x < X_MIN + SIZE + STEP) m_dir = M_RIGHT;
      else if (m_dir == M_DOWN && m_y + SIZE + STEP > Y_MAX) m_dir = M_UP;
      else if (m_dir == M_UP && m_y < Y_MIN + SIZE + STEP) m_dir = M_DOWN;
      if (m_dir == M_UP) m_y -= STEP;
      else if (m_dir == M_DOWN) m_y += STEP;
      else if (m_dir == M_LEFT) m_x -= STEP;
      else if (m_dir == M_RIGHT) m_x += STEP;
    end
  endtask

  // Drives Reset_n low between clock edges, checks the outputs are already
  // back at the centre, then releases Reset_n just after a rising edge.
  task automatic apply_reset(input string nm);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_cnt++;
    if (BallX !== 10'(m_x) || BallY !== 10'(m_y) || Ball_size !== 10'(SIZE))
      $display("FAIL %s_async: X/Y/size=%0d/%0d/%0d expected %0d/%0d/%0d",
               nm, BallX, BallY, Ball_size, m_x, m_y, SIZE);
    else pass_cnt++;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  // Drives one frame pulse. Checks that the position has not moved after
  // the 2nd edge, has moved after the 3rd, and then holds through the rest
  // of the pulse while keycode carries random noise.
  task automatic do_frame(input logic [7:0] kc, input int high_cyc, input int low_cyc,
                          input string nm);
    int ox, oy;
    bit stable;
    keycode = kc;
    @(posedge Clk);
    #1;
    frame_clk = 1'b1;
    ox = m_x;
    oy = m_y;
    @(posedge Clk);           // edge 1: first sample
    @(posedge Clk);           // edge 2
    #1;
    check_cnt++;
    if (BallX !== 10'(ox) || BallY !== 10'(oy))
      $display("FAIL %s_early: X/Y=%0d/%0d expected %0d/%0d", nm, BallX, BallY, ox, oy);
    else pass_cnt++;
    model_tick(kc);
    @(posedge Clk);           // edge 3: position update
    #1;
    check_cnt++;
    if (BallX !== 10'(m_x) || BallY !== 10'(m_y))
      $display("FAIL %s_step: X/Y=%0d/%0d expected %0d/%0d", nm, BallX, BallY, m_x, m_y);
    else pass_cnt++;
    stable = 1'b1;
    keycode = 8'($urandom_range(0, 255));
    for (int i = 3; i < high_cyc; i++) begin
      @(posedge Clk);
      #1;
      if (BallX !== 10'(m_x) || BallY !== 10'(m_y)) stable = 1'b0;
    end
    frame_clk = 1'b0;
    for (int i = 0; i < low_cyc; i++) begin
      @(posedge Clk);
      #1;
      if (BallX !== 10'(m_x) || BallY !== 10'(m_y)) stable = 1'b0;
    end
    check_cnt++;
    if (stable !== 1'b1)
      $display("FAIL %s_stable: X/Y=%0d/%0d expected %0d/%0d", nm, BallX, BallY, m_x, m_y);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    apply_reset("reset");
    for (int i = 0; i < 5; i++) do_frame(8'h00, 3, 3, "reset_idle");
    check_cnt++;
    if (BallX !== 10'd320 || BallY !== 10'd240 || Ball_size !== 10'd4)
      $display("FAIL reset_idle_final: X/Y/size=%0d/%0d/%0d expected 320/240/4",
               BallX, BallY, Ball_size);
    else pass_cnt++;
    $display("test_reset: X=%0d Y=%0d size=%0d", BallX, BallY, Ball_size);
  endtask

  task automatic test_right_then_idle();
    do_frame(8'h07, 3, 3, "right1");
    for (int i = 0; i < 9; i++) do_frame(8'h00, 4, 2, "coast");
    check_cnt++;
    if (BallX !== 10'd330 || BallY !== 10'd240)
      $display("FAIL coast_final: X/Y=%0d/%0d expected 330/240", BallX, BallY);
    else pass_cnt++;
    $display("test_right_then_idle: X=%0d Y=%0d", BallX, BallY);
  endtask

  task automatic test_right_wall();
    int exp_x[4] = '{634, 635, 634, 633};
    while (m_x < 633) do_frame(8'h07, 3, 2, "to_right");
    for (int i = 0; i < 4; i++) begin
      do_frame(8'h00, 3, 2, "right_wall");
      check_cnt++;
      if (BallX !== 10'(exp_x[i]))
        $display("FAIL right_wall_%0d: X=%0d expected %0d", i, BallX, exp_x[i]);
      else pass_cnt++;
    end
    $display("test_right_wall: X=%0d Y=%0d", BallX, BallY);
  endtask

  task automatic test_top_wall();
    int exp_y[3] = '{4, 5, 6};
    while (m_y > 5) do_frame(8'h1A, 3, 2, "to_top");
    for (int i = 0; i < 3; i++) begin
      do_frame((i == 0) ? 8'h1A : 8'h00, 3, 2, "top_wall");
      check_cnt++;
      if (BallY !== 10'(exp_y[i]))
        $display("FAIL top_wall_%0d: Y=%0d expected %0d", i, BallY, exp_y[i]);
      else pass_cnt++;
    end
    $display("test_top_wall: X=%0d Y=%0d", BallX, BallY);
  endtask

  task automatic test_long_high_and_reset();
    int y0;
    y0 = m_y;
    do_frame(8'h16, 1000, 3, "long_high");
    check_cnt++;
    if (BallY !== 10'(y0 + 1))
      $display("FAIL long_high_once: Y=%0d expected %0d", BallY, y0 + 1);
    else pass_cnt++;
    // reset in the middle of a frame pulse, before its tick lands
    keycode = 8'h16;
    @(posedge Clk);
    #1;
    frame_clk = 1'b1;
    apply_reset("mid_frame");
    do_frame(8'h00, 3, 3, "after_reset");
    check_cnt++;
    if (BallX !== 10'd320 || BallY !== 10'd240)
      $display("FAIL after_reset_idle: X/Y=%0d/%0d expected 320/240", BallX, BallY);
    else pass_cnt++;
    $display("test_long_high_and_reset: X=%0d Y=%0d", BallX, BallY);
  endtask

  task automatic test_pause();
    int exp_final;
`ifdef BALL_PAUSE_KEY_EN
    exp_final = 325;
`else
    exp_final = 331;
`endif
    apply_reset("pause");
    for (int i = 0; i < 3; i++) do_frame(8'h07, 3, 2, "pause_right");
    check_cnt++;
    if (BallX !== 10'd323) $display("FAIL pause_pre: X=%0d expected 323", BallX);
    else pass_cnt++;
    do_frame(8'h2C, 3, 2, "space1");
    for (int i = 0; i < 4; i++) do_frame(8'h00, 3, 2, "pause_idle");
    do_frame(8'h2C, 3, 2, "space2");
    for (int i = 0; i < 2; i++) do_frame(8'h00, 3, 2, "pause_after");
    check_cnt++;
    if (BallX !== 10'(exp_final))
      $display("FAIL pause_final: X=%0d expected %0d", BallX, exp_final);
    else pass_cnt++;
    $display("test_pause: X=%0d Y=%0d", BallX, BallY);
  endtask

  function automatic logic [7:0] rand_key();
    case ($urandom_range(0, 6))
      0: return 8'h00;
      1: return 8'h1A;
      2: return 8'h16;
      3: return 8'h04;
      4: return 8'h07;
      5: return 8'h2C;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      do_frame(rand_key(), $urandom_range(3, 6), $urandom_range(2, 5), "random");
    check_cnt++;
    if (BallX < 10'(X_MIN + SIZE) || BallX > 10'(X_MAX - SIZE) ||
        BallY < 10'(Y_MIN + SIZE) || BallY > 10'(Y_MAX - SIZE))
      $display("FAIL random_range: X/Y=%0d/%0d outside limits", BallX, BallY);
    else pass_cnt++;
    $display("test_random: X=%0d Y=%0d", BallX, BallY);
  endtask

  initial begin
    Reset_n = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'h00;
    model_reset();
    test_reset();
    test_right_then_idle();
    test_right_wall();
    test_top_wall();
    test_long_high_and_reset();
    test_pause();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
